// File: rtl/friscv_pkg.sv
// friscv_pkg: shared definitions for the Frisc-V juice dispenser control unit.
//   estado_t        : 4-bit FSM state encoding, codes 0..9 (also driven on db_estado)
//   DB_DEFAULT      : debug code reported for any illegal state
//   MAX_N_CH        : largest supported number of juice channels
//   codigo_debug()  : maps a state to its db_estado code
package friscv_pkg;

    localparam int unsigned MAX_N_CH = 8;

    typedef enum logic [3:0] {
        EstInicial   = 4'd0,
        EstEspera    = 4'd1,
        EstMedir     = 4'd2,
        EstAguarda   = 4'd3,
        EstSemCopo   = 4'd4,
        EstZera      = 4'd5,
        EstBombeando = 4'd6,
        EstPausa     = 4'd7,
        EstFim       = 4'd8,
        EstLibera    = 4'd9
    } estado_t;

    localparam logic [3:0] DB_DEFAULT = 4'hE;

    function automatic logic [3:0] codigo_debug(input estado_t e);
        case (e)
            EstInicial, EstEspera, EstMedir, EstAguarda, EstSemCopo,
            EstZera, EstBombeando, EstPausa, EstFim, EstLibera: return e;
            default: return DB_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/friscv_contador_seg.sv
// friscv_contador_seg: seconds counter for the pump phase.
//   clock, reset : system clock, synchronous active-high reset
//   zera         : clear the count
//   conta        : count one second this cycle
//   limite       : dose length in seconds
//   fim          : terminal flag, high when this counted second is the last one
module friscv_contador_seg
    import friscv_pkg::*;
#(
    parameter int unsigned TEMPO_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               zera,
    input  logic               conta,
    input  logic [TEMPO_W-1:0] limite,
    output logic               fim
);

    logic [TEMPO_W-1:0] contagem_q;

    // Terminal compare comes before the increment, so the count never wraps.
    assign fim = conta && (contagem_q == limite - TEMPO_W'(1));

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            contagem_q <= '0;
        end else if (conta && !fim) begin
            contagem_q <= contagem_q + TEMPO_W'(1);
        end
    end

endmodule

// File: rtl/friscv_dispensador_n.sv
// friscv_dispensador_n: N-channel juice dispenser control unit.
// Per request: cup measurement, then one pump driven for the channel's programmed seconds.
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   liga_frisc          : machine enable (level); low forces INICIAL
//   pedido[N_CH]        : request buttons, lowest set index wins
//   tempo_bomba         : per-channel pump time, channel i at [i*TEMPO_W +: TEMPO_W]
//   tick_seg            : one-cycle pulse per second
//   fim_medida          : measurement finished pulse
//   copo_posicionado    : cup present (level)
//   medir               : measurement start pulse
//   ativa_bomba[N_CH]   : one-hot pump enables
//   canal_sel           : latched channel of the current dose
//   pronto              : idle, accepting requests
//   fim_dose, erro_copo : dose complete / no cup or abort pulses
//   db_estado           : debug state code
// Optional feature: define FRISCV_PAUSA_EN to pause (instead of abort) on cup removal while pumping.
// All outputs are registered from the next-state decode, so there is no input-to-output path.
module friscv_dispensador_n
    import friscv_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned TEMPO_W = 6,
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    liga_frisc,
    input  logic [N_CH-1:0]         pedido,
    input  logic [N_CH*TEMPO_W-1:0] tempo_bomba,
    input  logic                    tick_seg,
    input  logic                    fim_medida,
    input  logic                    copo_posicionado,
    output logic                    medir,
    output logic [N_CH-1:0]         ativa_bomba,
    output logic [CH_W-1:0]         canal_sel,
    output logic                    pronto,
    output logic                    fim_dose,
    output logic                    erro_copo,
    output logic [3:0]              db_estado
);

    estado_t            estado_q, estado_d;
    logic [CH_W-1:0]    canal_d;
    logic [TEMPO_W-1:0] tempo_q, tempo_d;
    logic               conta, zera, fim_contagem;

    // A tick coinciding with cup removal is not counted.
    assign conta = (estado_q == EstBombeando) && tick_seg && copo_posicionado;
    assign zera  = (estado_q == EstZera);

    friscv_contador_seg #(
        .TEMPO_W (TEMPO_W)
    ) u_contador (
        .clock  (clock),
        .reset  (reset),
        .zera   (zera),
        .conta  (conta),
        .limite (tempo_q),
        .fim    (fim_contagem)
    );

    always_comb begin
        estado_d = estado_q;
        canal_d  = canal_sel;
        tempo_d  = tempo_q;
        case (estado_q)
            EstInicial: if (liga_frisc) estado_d = EstEspera;
            EstEspera: begin
                if (|pedido) begin
                    estado_d = EstMedir;
                    // Descending scan so the lowest set index is the one kept.
                    for (int i = N_CH - 1; i >= 0; i--) begin
                        if (pedido[i]) begin
                            canal_d = CH_W'(i);
                            tempo_d = tempo_bomba[i*TEMPO_W +: TEMPO_W];
                        end
                    end
                end
            end
            EstMedir:   estado_d = EstAguarda;
            EstAguarda: begin
                if (fim_medida) estado_d = copo_posicionado ? EstZera : EstSemCopo;
            end
            EstSemCopo: estado_d = EstLibera;
            EstZera:    estado_d = (tempo_q == '0) ? EstFim : EstBombeando;
            EstBombeando: begin
                if (!copo_posicionado) begin
`ifdef FRISCV_PAUSA_EN
                    estado_d = EstPausa;
`else
                    estado_d = EstSemCopo;
`endif
                end else if (fim_contagem) begin
                    estado_d = EstFim;
                end
            end
`ifdef FRISCV_PAUSA_EN
            EstPausa:   if (copo_posicionado) estado_d = EstBombeando;
`endif
            EstFim:     estado_d = EstLibera;
            EstLibera:  if (pedido == '0) estado_d = EstEspera;
            default:    estado_d = EstInicial;
        endcase
        if (!liga_frisc) estado_d = EstInicial;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= EstInicial;
            canal_sel   <= '0;
            tempo_q     <= '0;
            medir       <= 1'b0;
            ativa_bomba <= '0;
            pronto      <= 1'b0;
            fim_dose    <= 1'b0;
            erro_copo   <= 1'b0;
            db_estado   <= 4'd0;
        end else begin
            estado_q    <= estado_d;
            canal_sel   <= canal_d;
            tempo_q     <= tempo_d;
            medir       <= (estado_d == EstMedir);
            pronto      <= (estado_d == EstEspera);
            fim_dose    <= (estado_d == EstFim);
            erro_copo   <= (estado_d == EstSemCopo);
            ativa_bomba <= (estado_d == EstBombeando) ? (N_CH'(1) << canal_d) : '0;
            db_estado   <= codigo_debug(estado_d);
        end
    end

endmodule

// File: tb/tb_friscv_dispensador_n.sv
// Testbench for friscv_dispensador_n (N_CH=2, TEMPO_W=6): table vectors, random doses against a
// transaction-level model, and hand sequences for timing, abort and reset corners.
module tb_friscv_dispensador_n;

    logic        clock = 1'b0;
    logic        reset, liga_frisc, tick_seg, fim_medida, copo_posicionado;
    logic [1:0]  pedido;
    logic [11:0] tempo_bomba;
    logic        medir, pronto, fim_dose, erro_copo;
    logic [1:0]  ativa_bomba;
    logic [0:0]  canal_sel;
    logic [3:0]  db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    friscv_dispensador_n #(
        .N_CH    (2),
        .TEMPO_W (6)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .liga_frisc       (liga_frisc),
        .pedido           (pedido),
        .tempo_bomba      (tempo_bomba),
        .tick_seg         (tick_seg),
        .fim_medida       (fim_medida),
        .copo_posicionado (copo_posicionado),
        .medir            (medir),
        .ativa_bomba      (ativa_bomba),
        .canal_sel        (canal_sel),
        .pronto           (pronto),
        .fim_dose         (fim_dose),
        .erro_copo        (erro_copo),
        .db_estado        (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] ped;
        int         t0;
        int         t1;
        bit         copo;
        int         rm_at;   // remove cup after this many pumped ticks (0 = never)
        int         canal;
        int         ticks;
        int         fim;
        int         erro;
        logic [1:0] mask;
    } vetor_t;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
        end
    endtask

    task automatic passo();
        @(posedge clock);
        #1;
    endtask

    // Expected outcome of one dose from the behavioural rules.
    function automatic vetor_t modelo(input vetor_t v);
        vetor_t r = v;
        int p = int'(v.ped);
        int t;
        r.canal = $clog2(p & (~p + 1));
        t = (r.canal == 0) ? v.t0 : v.t1;
        r.mask = 2'b00;
        if (!v.copo) begin
            r.ticks = 0; r.fim = 0; r.erro = 1;
        end else begin
            if (t > 0) r.mask = 2'(1 << r.canal);
            if (v.rm_at > 0 && v.rm_at < t) begin
`ifdef FRISCV_PAUSA_EN
                r.ticks = t; r.fim = 1; r.erro = 0;
`else
                r.ticks = v.rm_at; r.fim = 0; r.erro = 1;
`endif
            end else begin
                r.ticks = t; r.fim = 1; r.erro = 0;
            end
        end
        return r;
    endfunction

    // Runs one full dose from ESPERA and compares the observed outcome with e.
    task automatic run_dose(input string nome, input vetor_t v, input vetor_t e, input int periodo);
        int  ticks = 0, fim = 0, erro = 0, rm_cnt = 0;
        bit  ok = 0, removido = 0;
        logic [1:0] mask = 2'b00;
        int  canal;
        tempo_bomba      = {6'(v.t1), 6'(v.t0)};
        copo_posicionado = 1'b1;
        pedido           = v.ped;
        passo();
        check({nome, "_medir"}, 32'(medir), 1);
        tempo_bomba = 12'($urandom);  // must not affect the latched dose
        passo();
        passo();
        fim_medida       = 1'b1;
        copo_posicionado = v.copo;
        passo();
        fim_medida       = 1'b0;
        copo_posicionado = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            fim  += int'(fim_dose);
            erro += int'(erro_copo);
            mask |= ativa_bomba;
            if (db_estado == 4'd9) begin
                ok = 1;
                break;
            end
            if (v.rm_at > 0 && !removido && ativa_bomba != 0 && ticks == v.rm_at) begin
                removido = 1;
                copo_posicionado = 1'b0;
            end else if (removido && !copo_posicionado) begin
                rm_cnt++;
                if (rm_cnt >= 10) copo_posicionado = 1'b1;
            end
            tick_seg = ((k % periodo) == periodo - 1);
            if (ativa_bomba != 0 && tick_seg && copo_posicionado) ticks++;
            passo();
        end
        tick_seg = 1'b0;
        copo_posicionado = 1'b1;
        canal = int'(canal_sel);
        check({nome, "_termina"}, 32'(ok), 1);
        check({nome, "_canal"}, canal, e.canal);
        check({nome, "_ticks"}, ticks, e.ticks);
        check({nome, "_fim_dose"}, fim, e.fim);
        check({nome, "_erro_copo"}, erro, e.erro);
        check({nome, "_mascara"}, 32'(mask), 32'(e.mask));
        passo();  // button still held: must stay in LIBERA
        check({nome, "_sem_repeticao"}, 32'(db_estado), 9);
        pedido = 2'b00;
        passo();
        check({nome, "_espera"}, 32'(db_estado), 1);
        if (!ok) begin
            reset = 1'b1;
            passo();
            reset = 1'b0;
            passo();
        end
    endtask

    // From ESPERA to the first BOMBEANDO cycle with the cup present.
    task automatic ate_bombeando(input logic [1:0] ped, input int t0, input int t1);
        tempo_bomba      = {6'(t1), 6'(t0)};
        copo_posicionado = 1'b1;
        pedido           = ped;
        passo();
        passo();
        fim_medida = 1'b1;
        passo();
        fim_medida = 1'b0;
        check("zera_bomba_desligada", 32'(ativa_bomba), 0);
        passo();
    endtask

    vetor_t tab[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; liga_frisc = 1'b1; pedido = 2'b00; tempo_bomba = '0;
        tick_seg = 1'b0; fim_medida = 1'b0; copo_posicionado = 1'b0;
        passo();
        passo();
        check("reset_saidas", {medir, ativa_bomba, canal_sel, pronto, fim_dose, erro_copo}, 0);
        check("reset_db_estado", 32'(db_estado), 0);
        reset = 1'b0; liga_frisc = 1'b0;
        passo();
        check("inicial_desligado", 32'(db_estado), 0);
        liga_frisc = 1'b1;
        passo();
        check("espera_db", 32'(db_estado), 1);
        check("espera_pronto", 32'(pronto), 1);

        tab[0] = '{2'b10, 3, 5, 1, 0, 1, 5, 1, 0, 2'b10};
        tab[1] = '{2'b11, 3, 5, 1, 0, 0, 3, 1, 0, 2'b01};
        tab[2] = '{2'b01, 3, 5, 0, 0, 0, 0, 0, 1, 2'b00};
        tab[3] = '{2'b01, 0, 4, 1, 0, 0, 0, 1, 0, 2'b00};
        tab[4] = '{2'b10, 2, 1, 1, 0, 1, 1, 1, 0, 2'b10};
`ifdef FRISCV_PAUSA_EN
        tab[5] = '{2'b10, 3, 5, 1, 2, 1, 5, 1, 0, 2'b10};
`else
        tab[5] = '{2'b10, 3, 5, 1, 2, 1, 2, 0, 1, 2'b10};
`endif
        tab[6] = '{2'b01, 40, 2, 1, 0, 0, 40, 1, 0, 2'b01};
        for (int i = 0; i < 7; i++) run_dose($sformatf("tab%0d", i), tab[i], tab[i], 4);

        for (int i = 0; i < 25; i++) begin
            vetor_t v;
            v.ped   = 2'($urandom_range(1, 3));
            v.t0    = $urandom_range(0, 7);
            v.t1    = $urandom_range(0, 7);
            v.copo  = ($urandom_range(0, 3) != 0);
            v.rm_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            run_dose($sformatf("rnd%0d", i), v, modelo(v), $urandom_range(1, 5));
        end

        // No cup: debug trace 3 -> 4 -> 9 -> 1.
        pedido = 2'b01; tempo_bomba = {6'd5, 6'd3};
        passo();
        passo();
        check("semcopo_aguarda", 32'(db_estado), 3);
        fim_medida = 1'b1; copo_posicionado = 1'b0;
        passo();
        fim_medida = 1'b0; copo_posicionado = 1'b1;
        check("semcopo_estado", 32'(db_estado), 4);
        check("semcopo_pulso", 32'(erro_copo), 1);
        passo();
        check("semcopo_libera", 32'(db_estado), 9);
        check("semcopo_pulso_unico", 32'(erro_copo), 0);
        pedido = 2'b00;
        passo();
        check("semcopo_espera", 32'(db_estado), 1);

        // Time 1: pump on two cycles after fim_medida, off with fim_dose after the terminal tick.
        ate_bombeando(2'b01, 1, 9);
        check("bomba_ligada", 32'(ativa_bomba), 1);
        tick_seg = 1'b1;
        passo();
        tick_seg = 1'b0;
        check("terminal_bomba_off", 32'(ativa_bomba), 0);
        check("terminal_fim_dose", 32'(fim_dose), 1);
        check("terminal_estado", 32'(db_estado), 8);
        passo();
        check("terminal_pulso_unico", 32'(fim_dose), 0);
        pedido = 2'b00;
        passo();

        // liga_frisc dropped mid-pump.
        ate_bombeando(2'b10, 9, 9);
        check("liga_bomba_ligada", 32'(ativa_bomba), 2);
        liga_frisc = 1'b0;
        passo();
        check("liga_bomba_off", 32'(ativa_bomba), 0);
        check("liga_inicial", 32'(db_estado), 0);
        check("liga_sem_pulsos", {fim_dose, erro_copo}, 0);
        pedido = 2'b00; liga_frisc = 1'b1;
        passo();
        check("liga_volta_espera", 32'(db_estado), 1);

        // reset mid-pump.
        ate_bombeando(2'b10, 9, 9);
        check("reset_bomba_ligada", 32'(ativa_bomba), 2);
        reset = 1'b1;
        passo();
        check("reset_bomba_off", 32'(ativa_bomba), 0);
        check("reset_meio_estado", 32'(db_estado), 0);
        check("reset_meio_canal", 32'(canal_sel), 0);
        reset = 1'b0; pedido = 2'b00;
        passo();
        check("reset_volta_espera", 32'(db_estado), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
